// File: rtl/trng_conditioner_if.sv
// Consumer-facing word handshake of the TRNG conditioner.
// The conditioner drives the word and valid pulse; the consumer drives the request level.
interface trng_conditioner_if #(
    parameter int TRNG_WIDTH = 4
);
    logic                  trng_req;
    logic [TRNG_WIDTH-1:0] trng_word;
    logic                  trng_valid;

    modport master (
        input  trng_req,
        output trng_word,
        output trng_valid
    );

    modport slave (
        output trng_req,
        input  trng_word,
        input  trng_valid
    );
endinterface

// File: rtl/trng_conditioner.sv
// TRNG conditioner: synchronises a raw entropy bit, samples it on a divided strobe,
// runs a repetition-count health test, debiases with a von Neumann corrector and
// packs the surviving bits into words that are handed out one per valid pulse.
module trng_conditioner #(
    parameter int TRNG_WIDTH = 4,
    parameter int SAMPLE_DIV = 4,
    parameter int REP_LIMIT  = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               raw_bit,
    trng_conditioner_if.master tif,
    output logic               health_fail
);
    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int REP_W = $clog2(REP_LIMIT + 1);
    localparam int CNT_W = $clog2(TRNG_WIDTH + 1);

    logic                  sync1_q, sync1_d, sync2_q, sync2_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic                  seen_q, seen_d;
    logic                  prev_q, prev_d;
    logic [REP_W-1:0]      rep_q, rep_d;
    logic                  fail_q, fail_d;
    logic                  pair_q, pair_d;
    logic                  a_q, a_d;
    logic [TRNG_WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [TRNG_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_vld_q, hold_vld_d;
    logic [TRNG_WIDTH-1:0] word_q, word_d;
    logic                  valid_q, valid_d;

    logic raw_s, strobe, trip, complete, emit, emit_bit;

    assign raw_s    = sync2_q;
    assign strobe   = (div_q == DIV_W'(SAMPLE_DIV - 1));
    assign trip     = (rep_q == REP_W'(REP_LIMIT));
    assign complete = (cnt_q == CNT_W'(TRNG_WIDTH));

    // Synchroniser, sample divider and repetition-count health test
    always_comb begin
        sync1_d = raw_bit;
        sync2_d = sync1_q;
        div_d   = strobe ? '0 : div_q + 1'b1;
        seen_d  = seen_q;
        prev_d  = prev_q;
        rep_d   = rep_q;
        if (strobe) begin
            seen_d = 1'b1;
            prev_d = raw_s;
            if (!seen_q || (raw_s != prev_q))
                rep_d = REP_W'(1);
            else if (!trip)
                rep_d = rep_q + 1'b1;
        end
        // once tripped the source is considered dead until reset
        fail_d = fail_q | trip;
    end

    // Von Neumann corrector over non-overlapping sample pairs; first of pair kept in a_q
    always_comb begin
        pair_d   = pair_q;
        a_d      = a_q;
        emit     = 1'b0;
        emit_bit = a_q;       // (1,0) -> 1, (0,1) -> 0: the emitted bit is the first sample
        if (strobe && !fail_q) begin
            pair_d = ~pair_q;
            if (!pair_q)
                a_d = raw_s;
            else if (a_q != raw_s)
                emit = 1'b1;
        end
    end

    // Packer, hold register and registered output handshake
    always_comb begin
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        word_d     = word_q;
        valid_d    = 1'b0;
        if (fail_q) begin
            hold_vld_d = 1'b0;
        end else begin
            if (complete && !hold_vld_q) begin
                // move the word out; a bit arriving on the same edge starts the next word
                hold_d     = sr_q;
                hold_vld_d = 1'b1;
                sr_d       = emit ? {{(TRNG_WIDTH-1){1'b0}}, emit_bit} : '0;
                cnt_d      = emit ? CNT_W'(1) : '0;
            end else if (emit && !complete) begin
                sr_d  = {sr_q[TRNG_WIDTH-2:0], emit_bit};
                cnt_d = cnt_q + 1'b1;
            end
            // load needs an empty hold, delivery a full one, so they never collide;
            // a trip in this cycle suppresses the delivery
            if (hold_vld_q && tif.trng_req && !trip) begin
                valid_d    = 1'b1;
                word_d     = hold_q;
                hold_vld_d = 1'b0;
            end
        end
    end

    // State registers, all cleared by the asynchronous reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            div_q      <= '0;
            seen_q     <= 1'b0;
            prev_q     <= 1'b0;
            rep_q      <= '0;
            fail_q     <= 1'b0;
            pair_q     <= 1'b0;
            a_q        <= 1'b0;
            sr_q       <= '0;
            cnt_q      <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            word_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            div_q      <= div_d;
            seen_q     <= seen_d;
            prev_q     <= prev_d;
            rep_q      <= rep_d;
            fail_q     <= fail_d;
            pair_q     <= pair_d;
            a_q        <= a_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            word_q     <= word_d;
            valid_q    <= valid_d;
        end
    end

    assign tif.trng_word  = word_q;
    assign tif.trng_valid = valid_q;
    assign health_fail    = fail_q;
endmodule

// File: tb/tb_trng_conditioner.sv
// Bench for trng_conditioner: table-driven directed vectors on a SAMPLE_DIV=1 instance,
// hand sequences for handshake/health/reset corners, and a randomized run on a
// SAMPLE_DIV=4 instance scored against a stream-level reference model.
module tb_trng_conditioner;
    localparam int W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn1 = 1'b1, raw1 = 1'b0, hf1;
    logic resetn4 = 1'b1, raw4 = 1'b0, hf4;

    trng_conditioner_if #(.TRNG_WIDTH(W)) if1 ();
    trng_conditioner_if #(.TRNG_WIDTH(W)) if4 ();

    trng_conditioner #(.TRNG_WIDTH(W), .SAMPLE_DIV(1), .REP_LIMIT(32)) dut1 (
        .clk(clk), .resetn(resetn1), .raw_bit(raw1), .tif(if1), .health_fail(hf1));
    trng_conditioner #(.TRNG_WIDTH(W), .SAMPLE_DIV(4), .REP_LIMIT(32)) dut4 (
        .clk(clk), .resetn(resetn4), .raw_bit(raw4), .tif(if4), .health_fail(hf4));

    int pass_cnt = 0, total_cnt = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // valid-pulse monitors
    int v1_total = 0, v1_dbl = 0, v4_dbl = 0;
    logic v1_prev = 1'b0, v4_prev = 1'b0;
    logic [W-1:0] got4[$];
    always @(negedge clk) begin
        if (if1.trng_valid) begin
            v1_total++;
            if (v1_prev) v1_dbl++;
        end
        v1_prev = if1.trng_valid;
        if (if4.trng_valid) begin
            got4.push_back(if4.trng_word);
            if (v4_prev) v4_dbl++;
        end
        v4_prev = if4.trng_valid;
    end

    // reset dut1, releasing on a falling clock edge
    task automatic reset1();
        resetn1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn1 = 1'b1;
    endtask

    // one raw bit per cycle, MSB of the used field first
    task automatic feed(input logic [15:0] r, input int n);
        for (int i = 0; i < n; i++) begin
            raw1 = r[n-1-i];
            @(negedge clk);
        end
    endtask

    // 0,0,1,1,... : equal pairs that the corrector discards
    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            raw1 = ((k % 4) < 2) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [15:0] raw;
        int          nbits;
        logic        req;
        logic [W-1:0] exp_word;
        int          exp_cnt;
    } vec_t;

    vec_t tv[8];
    int   c0;
    int   vq[$];
    logic [W-1:0] expw[$];

    initial begin
        tv[0] = '{16'h00AA,  8, 1'b1, 4'hF, 1};  // 10 10 10 10
        tv[1] = '{16'h0069,  8, 1'b1, 4'h6, 1};  // 01 10 10 01
        tv[2] = '{16'h12E1, 14, 1'b1, 4'h6, 1};  // 01 00 10 11 10 00 01
        tv[3] = '{16'h0055,  8, 1'b1, 4'h0, 1};  // 01 01 01 01
        tv[4] = '{16'h09E4, 12, 1'b1, 4'hA, 1};  // 10 01 11 10 01 00
        tv[5] = '{16'h002A,  6, 1'b1, 4'h0, 0};  // only three debiased bits
        tv[6] = '{16'hA566, 16, 1'b1, 4'h5, 2};  // two words: 1100 then 0101
        tv[7] = '{16'h00AA,  8, 1'b0, 4'h0, 0};  // no request: word stays held

        if1.trng_req = 1'b0;
        if4.trng_req = 1'b0;
        #1;
        resetn1 = 1'b0;
        resetn4 = 1'b0;
        #1;
        chk("reset_valid", int'(if1.trng_valid), 0);
        chk("reset_word", int'(if1.trng_word), 0);
        chk("reset_health", int'(hf1), 0);

        // directed table
        for (int vi = 0; vi < 8; vi++) begin
            if1.trng_req = tv[vi].req;
            reset1();
            c0 = v1_total;
            feed(tv[vi].raw, tv[vi].nbits);
            idle(16);
            chk($sformatf("vec%0d_count", vi), v1_total - c0, tv[vi].exp_cnt);
            chk($sformatf("vec%0d_word", vi), int'(if1.trng_word), int'(tv[vi].exp_word));
            chk($sformatf("vec%0d_health", vi), int'(hf1), 0);
        end

        // held word is released exactly one cycle after req rises, then nothing more
        c0 = v1_total;
        chk("req_low_no_valid", int'(if1.trng_valid), 0);
        if1.trng_req = 1'b1;
        @(negedge clk);
        chk("req_rise_valid", int'(if1.trng_valid), 1);
        chk("req_rise_word", int'(if1.trng_word), 4'hF);
        @(negedge clk);
        chk("req_rise_single", int'(if1.trng_valid), 0);
        idle(16);
        chk("req_rise_count", v1_total - c0, 1);

        // health test: raw stuck at 1; the 32nd one is sampled at edge 34
        if1.trng_req = 1'b1;
        raw1 = 1'b1;
        reset1();
        for (int n = 1; n <= 36; n++) begin
            @(negedge clk);
            if (n == 34) chk("health_before_trip", int'(hf1), 0);
            if (n == 35) chk("health_after_trip", int'(hf1), 1);
        end
        c0 = v1_total;
        for (int n = 0; n < 40; n++) begin
            raw1 = n[0];
            @(negedge clk);
        end
        chk("health_no_valid", v1_total - c0, 0);
        chk("health_sticky", int'(hf1), 1);

        // reset mid-word: partial bits are discarded
        if1.trng_req = 1'b1;
        reset1();
        feed(16'h0AAA, 12);
        idle(2);
        chk("prereset_word", int'(if1.trng_word), 4'hF);
        resetn1 = 1'b0;
        #1;
        chk("midreset_valid", int'(if1.trng_valid), 0);
        chk("midreset_word", int'(if1.trng_word), 0);
        chk("midreset_health", int'(hf1), 0);
        @(negedge clk);
        @(negedge clk);
        resetn1 = 1'b1;
        c0 = v1_total;
        feed(16'h0066, 8);
        idle(16);
        chk("postreset_count", v1_total - c0, 1);
        chk("postreset_word", int'(if1.trng_word), 4'h5);
        chk("dut1_no_double", v1_dbl, 0);

        // randomized run on the divided instance
        begin
            int   burst;
            logic rq;
            int   n, nbits, diff;
            int   bits[$];
            burst = 0;
            rq    = 1'b0;
            @(negedge clk);
            resetn4 = 1'b1;
            for (int j = 0; j < 3000; j++) begin
                raw4 = 1'($urandom_range(0, 1));
                vq.push_back(int'(raw4));
                if (burst == 0) begin
                    rq    = ~rq;
                    burst = $urandom_range(1, 8);
                end
                burst--;
                if (j >= 2950) rq = 1'b1;
                if4.trng_req = rq;
                @(negedge clk);
            end
            // reference: raw is seen two cycles late, sampled every 4th cycle,
            // paired, debiased, then grouped MSB-first into words
            n = vq.size();
            for (int s = 1; s + 4 + 3 <= n; s += 8)
                if (vq[s] != vq[s+4]) bits.push_back(vq[s]);
            nbits = bits.size();
            for (int b = 0; b + W <= nbits; b += W) begin
                logic [W-1:0] w;
                w = '0;
                for (int k = 0; k < W; k++) w = {w[W-2:0], 1'(bits[b+k])};
                expw.push_back(w);
            end
            diff = expw.size() - got4.size();
            chk("rand_word_count", int'(diff == 0 || diff == 1), 1);
            chk("rand_enough_words", int'(got4.size() > 10), 1);
            for (int i = 0; i < got4.size() && i < expw.size(); i++)
                chk($sformatf("rand_word%0d", i), int'(got4[i]), int'(expw[i]));
            chk("rand_no_double", v4_dbl, 0);
            chk("rand_health", int'(hf4), 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
